// File: rtl/phy_tx_lane_sched.sv
// -----------------------------------------------------------------------------
// phy_tx_lane_sched
//
// Purpose:
//   Scheduler in front of the PHY TX datapath. NUM_REQ show-ahead requester
//   FIFOs share the two TX lanes. A round-robin arbiter picks one non-empty
//   requester per cycle and pops it combinationally. The granted word is
//   registered one cycle later onto lane 0 or lane 1, and the lanes are used
//   alternately. Traffic is throttled with high/low watermarks on the
//   downstream buffer occupancy. Start-up is sequenced by a
//   RESET/INIT/IDLE/ACTIVE state machine.
//
// Configuration macro:
//   TX_SCHED_PRIO0_EN - when defined, requester 0 has strict priority over the
//                       round-robin order. The pointer advances only on grants
//                       to other requesters.
//
// Ports:
//   clk_2f          in   single rising-edge clock
//   reset           in   synchronous, active-high reset
//   init            in   re-enter INIT and relatch thresholds
//   umbral_alto_in  in   pause threshold (high watermark)
//   umbral_bajo_in  in   resume threshold (low watermark)
//   tx_fill         in   downstream buffer occupancy
//   req_empty       in   per-requester FIFO empty flags
//   req_data        in   FIFO head words, requester i at [i*DATA_W +: DATA_W]
//   req_pop         out  one-hot pop, same cycle as the grant
//   data_out_0/1    out  lane 0 / lane 1 words
//   valid_out_0/1   out  lane 0 / lane 1 valid strobes
//   state           out  RESET=0, INIT=1, IDLE=2, ACTIVE=3
//   umbral_alto_out out  latched high threshold
//   umbral_bajo_out out  latched low threshold
//   paused          out  throttle active
//   idle_out        out  high while in IDLE
// -----------------------------------------------------------------------------
module phy_tx_lane_sched #(
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 4,
  parameter int TH_W    = 3
) (
  input  logic                      clk_2f,
  input  logic                      reset,
  input  logic                      init,
  input  logic [TH_W-1:0]           umbral_alto_in,
  input  logic [TH_W-1:0]           umbral_bajo_in,
  input  logic [TH_W-1:0]           tx_fill,
  input  logic [NUM_REQ-1:0]        req_empty,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_pop,
  output logic [DATA_W-1:0]         data_out_0,
  output logic                      valid_out_0,
  output logic [DATA_W-1:0]         data_out_1,
  output logic                      valid_out_1,
  output logic [1:0]                state,
  output logic [TH_W-1:0]           umbral_alto_out,
  output logic [TH_W-1:0]           umbral_bajo_out,
  output logic                      paused,
  output logic                      idle_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PTR_W-1:0]    r_ptr;
  logic                r_lane_sel;
  logic                r_paused;
  logic                w_paused_next;
  logic [TH_W-1:0]     r_alto;
  logic [TH_W-1:0]     r_bajo;
  logic [DATA_W-1:0]   r_data0;
  logic [DATA_W-1:0]   r_data1;
  logic                r_valid0;
  logic                r_valid1;
  logic                r_idle;

  logic                w_any_req;
  logic                w_grant;
  logic [PTR_W-1:0]    w_rr_win;
  logic [PTR_W-1:0]    w_win;
  logic                w_ptr_upd;
  logic [PTR_W-1:0]    w_win_inc;
  logic [NUM_REQ-1:0]  w_pop;
  logic [DATA_W-1:0]   w_win_data;

  // Round-robin pick. The request vector is rotated right by the pointer, so
  // the lowest set bit of the rotated vector is the first non-empty requester
  // at or after the pointer. Adding the pointer back gives the absolute index.
  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] nonempty,
    input logic [PTR_W-1:0]   ptr
  );
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [PTR_W-1:0]     off;
    logic [PTR_W:0]       sum;
    dbl = {nonempty, nonempty} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    // Scan downwards so that the lowest set bit is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = PTR_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM_REQ_EXT) begin
      sum = sum - NUM_REQ_EXT;
    end
    return sum[PTR_W-1:0];
  endfunction

  assign w_any_req = ~&req_empty;
  assign w_rr_win  = rr_pick(~req_empty, r_ptr);

  // A grant requires ACTIVE state, no throttle, and no pending init.
  // A requester that empties in the same cycle is still granted, because the
  // word being popped is the one at its head.
  assign w_grant = (r_state == ST_ACTIVE) && !r_paused && !init && w_any_req;

  // Winner selection: round-robin, optionally overridden by strict priority
  // for requester 0.
  always_comb begin
    w_win     = w_rr_win;
    w_ptr_upd = 1'b1;
`ifdef TX_SCHED_PRIO0_EN
    if (!req_empty[0]) begin
      w_win     = '0;
      w_ptr_upd = 1'b0;
    end else begin
      w_win     = w_rr_win;
      w_ptr_upd = 1'b1;
    end
`else
    w_win     = w_rr_win;
    w_ptr_upd = 1'b1;
`endif
  end

  assign w_win_inc = (w_win == LAST_IDX) ? '0 : (w_win + PTR_W'(1));

  // One-hot pop decode and head-word mux for the winner.
  always_comb begin
    w_pop      = '0;
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pop[k] = w_grant && (w_win == PTR_W'(k));
      if (w_win == PTR_W'(k)) begin
        w_win_data = req_data[k*DATA_W +: DATA_W];
      end else begin
        w_win_data = w_win_data;
      end
    end
  end

  assign req_pop = w_pop;

  // FSM next-state logic. INIT always lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RESET: begin
        w_state_next = ST_INIT;
      end
      ST_INIT: begin
        w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (init) begin
          w_state_next = ST_INIT;
        end else if (w_any_req) begin
          w_state_next = ST_ACTIVE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (init) begin
          w_state_next = ST_INIT;
        end else if (!w_any_req) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_ACTIVE;
        end
      end
      default: begin
        w_state_next = ST_RESET;
      end
    endcase
  end

  // FSM state register and the IDLE flag, which is registered from the
  // next state so that it lines up with the state output.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_state <= ST_RESET;
      r_idle  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idle  <= (w_state_next == ST_IDLE);
    end
  end

  // Threshold latch. An inverted or degenerate pair (alto <= bajo) would make
  // the hysteresis meaningless, so it falls back to the widest window.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_alto <= '0;
      r_bajo <= '0;
    end else if (r_state == ST_INIT) begin
      if (umbral_alto_in > umbral_bajo_in) begin
        r_alto <= umbral_alto_in;
        r_bajo <= umbral_bajo_in;
      end else begin
        r_alto <= '1;
        r_bajo <= '0;
      end
    end else begin
      r_alto <= r_alto;
      r_bajo <= r_bajo;
    end
  end

  // Throttle next value with hysteresis. A pending init forces it clear, so
  // init wins over a simultaneous pause condition.
  always_comb begin
    w_paused_next = r_paused;
    if ((r_state == ST_RESET) || (r_state == ST_INIT) || init) begin
      w_paused_next = 1'b0;
    end else if (tx_fill >= r_alto) begin
      w_paused_next = 1'b1;
    end else if (tx_fill <= r_bajo) begin
      w_paused_next = 1'b0;
    end else begin
      w_paused_next = r_paused;
    end
  end

  // Throttle register.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_paused <= 1'b0;
    end else begin
      r_paused <= w_paused_next;
    end
  end

  // Round-robin pointer. It survives INIT so that arbitration fairness is
  // kept across threshold reloads, and it is cleared only by reset.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant && w_ptr_upd) begin
      r_ptr <= w_win_inc;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Lane output registers. The granted word goes onto the lane chosen by
  // lane_sel; the idle lane keeps its last data with valid low.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_data0    <= '0;
      r_data1    <= '0;
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_lane_sel <= 1'b0;
    end else begin
      r_valid0 <= w_grant && !r_lane_sel;
      r_valid1 <= w_grant && r_lane_sel;
      if (w_grant) begin
        if (r_lane_sel) begin
          r_data1 <= w_win_data;
          r_data0 <= r_data0;
        end else begin
          r_data0 <= w_win_data;
          r_data1 <= r_data1;
        end
        r_lane_sel <= ~r_lane_sel;
      end else if (r_state == ST_INIT) begin
        r_data0    <= r_data0;
        r_data1    <= r_data1;
        r_lane_sel <= 1'b0;
      end else begin
        r_data0    <= r_data0;
        r_data1    <= r_data1;
        r_lane_sel <= r_lane_sel;
      end
    end
  end

  assign data_out_0      = r_data0;
  assign valid_out_0     = r_valid0;
  assign data_out_1      = r_data1;
  assign valid_out_1     = r_valid1;
  assign state           = r_state;
  assign umbral_alto_out = r_alto;
  assign umbral_bajo_out = r_bajo;
  assign paused          = r_paused;
  assign idle_out        = r_idle;

endmodule

// File: doc/phy_tx_lane_sched.md
Name: phy_tx_lane_sched

Overview:
- Scheduler in front of the PHY TX datapath (mux -> byte striping -> parallel/serial lanes).
- Shares the two TX lane inputs among NUM_REQ show-ahead request FIFOs using round-robin arbitration.
- Alternates granted words between lane 0 and lane 1.
- Throttles traffic with high/low occupancy thresholds on the downstream buffer, and sequences start-up through a RESET/INIT/IDLE/ACTIVE state machine.

Parameters:
DATA_W, 8, width of one data word
NUM_REQ, 4, number of requester FIFOs (2..8)
TH_W, 3, width of threshold and occupancy fields

Ports:
clk_2f  in  1  single clock; everything in this block is clocked on its rising edge
reset  in  1  synchronous, active-high reset
init  in  1  request to re-enter INIT and relatch thresholds
umbral_alto_in  in  TH_W  pause threshold (high watermark)
umbral_bajo_in  in  TH_W  resume threshold (low watermark)
tx_fill  in  TH_W  current downstream buffer occupancy
req_empty  in  NUM_REQ  per-requester FIFO empty flag
req_data  in  NUM_REQ*DATA_W  FIFO head words; requester i occupies bits [i*DATA_W +: DATA_W]
req_pop  out  NUM_REQ  one-hot pop, combinational, same cycle as grant
data_out_0  out  DATA_W  lane 0 word to PHY TX
valid_out_0  out  1  lane 0 valid
data_out_1  out  DATA_W  lane 1 word to PHY TX
valid_out_1  out  1  lane 1 valid
state  out  2  current FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3
umbral_alto_out  out  TH_W  latched high threshold
umbral_bajo_out  out  TH_W  latched low threshold
paused  out  1  throttle active
idle_out  out  1  high in IDLE

Behaviour:
- Reset (any cycle, including mid-transfer), applied on the next edge:
  - all outputs 0; state=RESET; paused=0.
  - lane_sel=0; round-robin pointer set so requester 0 is checked first.
- FSM transitions:
  - RESET -> INIT on the first edge with reset=0.
  - INIT (exactly one cycle) latches thresholds, then -> IDLE.
  - IDLE -> ACTIVE when any req_empty bit is 0.
  - ACTIVE -> IDLE when all req_empty bits are 1.
  - init=1 in IDLE or ACTIVE -> INIT; no grant is issued in that cycle.
- Threshold latch in INIT:
  - if umbral_alto_in > umbral_bajo_in, latch both as given.
  - otherwise latch alto = all ones, bajo = 0.
- Throttle, registered, with hysteresis:
  - paused is set on the next edge when tx_fill >= alto.
  - paused is cleared on the next edge when tx_fill <= bajo.
  - otherwise paused holds its value.
  - paused is forced to 0 in RESET and INIT.
- Grant: issued only when state=ACTIVE, paused=0, init=0 and at least one requester is non-empty.
  - winner is the first non-empty requester searching from pointer, wrapping NUM_REQ-1 -> 0.
  - req_pop[winner]=1 in the same cycle; pointer <= winner+1 (mod NUM_REQ).
  - never pop an empty requester; at most one pop per cycle.
- Output, 1-cycle latency:
  - on the edge after a grant, the word is registered onto the lane given by lane_sel; that lane's valid=1; lane_sel toggles.
  - the other lane's valid=0 and its data holds.
  - cycles with no grant: both valid=0, data holds, lane_sel unchanged.
  - lane_sel returns to 0 on reset and on every INIT.
- Simultaneous events:
  - init=1 together with the pause condition: INIT wins.
  - requester FIFO becoming empty in the same cycle it is granted: the grant stands (the word was at the head).

Optional Feature:
Macro TX_SCHED_PRIO0_EN.
- Defined: requester 0 has strict priority; whenever it is non-empty and a grant is allowed, it wins. The pointer is updated only on grants to other requesters.
- Undefined: pure round-robin as above.

Test Plan:
- reset=1 for 2 cycles, then 0, with alto_in=6, bajo_in=2 -> state: 0, 1, 2; umbral_alto_out=6, umbral_bajo_out=2; all valids 0.
- Requesters 0..3 each hold one word (0xA0, 0xA1, 0xA2, 0xA3), tx_fill=0 -> pops in order 0,1,2,3. Lane 0 gets 0xA0 and 0xA2, lane 1 gets 0xA1 and 0xA3, each one cycle after its pop. State ends back in IDLE.
- Continuous traffic; tx_fill ramps 0..7 then back down to 0 -> paused rises the edge after tx_fill=6 and no pops occur while high. paused clears the edge after tx_fill=2 and grants resume from the saved pointer.
- INIT with alto_in=2, bajo_in=5 -> latched alto=7, bajo=0.
- Assert reset mid-stream after 3 grants -> next edge: all outputs 0, state=RESET. The first grant after restart goes to requester 0 on lane 0.
- With TX_SCHED_PRIO0_EN defined, requesters 0 and 2 both continuously non-empty -> only requester 0 is popped. Without the macro -> pops alternate 0, 2, 0, 2.
